// File: rtl/fir_line_buffer.sv
// fir_line_buffer: five-row vertical window generator for a 5x5 FIR.
// Four circular line memories hold the previous four image lines. Every
// accepted pixel reads the stored column at the current address, then
// overwrites the oldest line at that address, so the registered outputs
// present one vertically aligned 5-pixel column per accepted pixel.
//
// Handshake: in_valid qualifies in_pixel/in_sof; there is no ready, so every
// cycle with in_valid=1 consumes one pixel. out_valid is a one-cycle
// qualifier for pixel0..pixel4 and is only raised once four complete lines
// of the current frame are stored; pixel0..pixel4 hold between accepted
// pixels.
module fir_line_buffer #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_BITS  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic [7:0] pixel0,
  output logic [7:0] pixel1,
  output logic [7:0] pixel2,
  output logic [7:0] pixel3,
  output logic [7:0] pixel4,
  output logic       out_valid,
  output logic       sof_err
);

  // Line memory address width; the column counter may be wider.
  localparam int ADDR_BITS = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [2:0] FULL_ROW = 3'd4;

  logic [COL_BITS-1:0]  col;
  logic [2:0]           row;
  logic [1:0]           wr_line;

  logic [COL_BITS-1:0]  eff_col;
  logic [2:0]           eff_row;
  logic [ADDR_BITS-1:0] addr;
  logic                 line_end;
  logic [1:0]           rd_line1;
  logic [1:0]           rd_line2;
  logic [1:0]           rd_line3;

  logic [7:0] line_mem [4][IMG_WIDTH];

  // A start-of-frame pixel is handled as row 0, column 0 whatever the
  // counters hold; the line after the write pointer is the next-oldest.
  always_comb begin
    eff_col  = in_sof ? '0 : col;
    eff_row  = in_sof ? '0 : row;
    addr     = eff_col[ADDR_BITS-1:0];
    line_end = (eff_col == LAST_COL);
    rd_line1 = wr_line + 2'd1;
    rd_line2 = wr_line + 2'd2;
    rd_line3 = wr_line + 2'd3;
  end

  // Column/row counters and line rotation pointer advance per accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      wr_line <= '0;
    end else if (in_valid) begin
      if (line_end) begin
        col     <= '0;
        wr_line <= wr_line + 2'd1;
        row     <= (eff_row == FULL_ROW) ? FULL_ROW : eff_row + 3'd1;
      end else begin
        col <= eff_col + COL_BITS'(1);
        row <= eff_row;
      end
    end
  end

  // Overwrite the oldest line at the current column (old value already read).
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      line_mem[wr_line][addr] <= in_pixel;
    end
  end

  // Registered column output; the oldest line is read before it is replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixel0    <= '0;
      pixel1    <= '0;
      pixel2    <= '0;
      pixel3    <= '0;
      pixel4    <= '0;
    end else begin
      out_valid <= in_valid && (eff_row == FULL_ROW);
      if (in_valid) begin
        pixel0 <= line_mem[wr_line][addr];
        pixel1 <= line_mem[rd_line1][addr];
        pixel2 <= line_mem[rd_line2][addr];
        pixel3 <= line_mem[rd_line3][addr];
        pixel4 <= in_pixel;
      end
    end
  end

  // Sticky error: a start-of-frame arrived while a line was part-way through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_err <= 1'b0;
    end else if (in_valid && in_sof && (col != '0)) begin
      sof_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_line_buffer.sv
// Directed bench for fir_line_buffer with an 8-pixel line.
// A frame-relative image array records every pixel sent; the expected
// column for a pixel at row r (r >= 4) is rows r-4..r of that array.
module tb_fir_line_buffer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4;
  logic       out_valid;
  logic       sof_err;

  logic [39:0] col_out;
  logic [7:0]  img [8][W];

  int tests_run = 0;
  int tests_failed = 0;

  assign col_out = {pixel0, pixel1, pixel2, pixel3, pixel4};

  fir_line_buffer #(.IMG_WIDTH(W), .COL_BITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2),
    .pixel3(pixel3), .pixel4(pixel4), .out_valid(out_valid), .sof_err(sof_err)
  );

  // clock
  always #5 clk = ~clk;

  // Frame 0 uses row*16+col; later frames use a unique {frame,row,col} tag.
  function automatic logic [7:0] pv(input int f, input int r, input int c);
    if (f == 0) return 8'(r * 16 + c);
    return 8'((f << 6) | (r << 3) | c);
  endfunction

  function automatic logic [39:0] exp_col(input int r, input int c);
    return {img[r-4][c], img[r-3][c], img[r-2][c], img[r-1][c], img[r][c]};
  endfunction

  // One clock with the given inputs; outputs are sampled 1 time unit later.
  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    in_valid = v;
    in_sof   = s;
    in_pixel = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF);
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    tests_run++;
    if (col_out !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_pixels got %h exp 0", col_out);
    end
    tests_run++;
    if (sof_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_sof_err got %b exp 0", sof_err);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = pv(0, r, c);
        drive(1'b1, 1'b0, img[r][c]);
        tests_run++;
        if (out_valid !== (r == 4)) begin
          tests_failed++;
          $display("FAIL cont_valid r=%0d c=%0d got %b exp %b", r, c, out_valid, (r == 4));
        end
        tests_run++;
        if (r == 4 && col_out !== exp_col(r, c)) begin
          tests_failed++;
          $display("FAIL cont_data r=%0d c=%0d got %h exp %h", r, c, col_out, exp_col(r, c));
        end else if (r < 4 && pixel4 !== img[r][c]) begin
          tests_failed++;
          $display("FAIL cont_pixel4 r=%0d c=%0d got %h exp %h", r, c, pixel4, img[r][c]);
        end
        if (r == 4 && c == 2) begin
          tests_run++;
          if (col_out !== 40'h0212223242) begin
            tests_failed++;
            $display("FAIL cont_0x42 got %h exp 0212223242", col_out);
          end
        end
      end
    end
  endtask

  task automatic test_gapped();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = pv(0, r, c);
        drive(1'b1, 1'b0, img[r][c]);
        tests_run++;
        if (out_valid !== (r == 4)) begin
          tests_failed++;
          $display("FAIL gap_valid r=%0d c=%0d got %b exp %b", r, c, out_valid, (r == 4));
        end
        if (r == 4) begin
          tests_run++;
          if (col_out !== exp_col(r, c)) begin
            tests_failed++;
            $display("FAIL gap_data r=%0d c=%0d got %h exp %h", r, c, col_out, exp_col(r, c));
          end
        end
        drive(1'b0, 1'b1, 8'hEE);
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL gap_idle_valid r=%0d c=%0d got %b exp 0", r, c, out_valid);
        end
        tests_run++;
        if (r == 4 && col_out !== exp_col(r, c)) begin
          tests_failed++;
          $display("FAIL gap_hold r=%0d c=%0d got %h exp %h", r, c, col_out, exp_col(r, c));
        end else if (pixel4 !== img[r][c]) begin
          tests_failed++;
          $display("FAIL gap_hold_p4 r=%0d c=%0d got %h exp %h", r, c, pixel4, img[r][c]);
        end
      end
    end
  endtask

  task automatic test_new_frame();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < ((f == 0) ? 6 : 5); r++) begin
        for (int c = 0; c < W; c++) begin
          img[r][c] = pv(f, r, c);
          drive(1'b1, (r == 0 && c == 0), img[r][c]);
          tests_run++;
          if (out_valid !== (r >= 4)) begin
            tests_failed++;
            $display("FAIL frame_valid f=%0d r=%0d c=%0d got %b exp %b", f, r, c, out_valid, (r >= 4));
          end
          if (r >= 4) begin
            tests_run++;
            if (col_out !== exp_col(r, c)) begin
              tests_failed++;
              $display("FAIL frame_data f=%0d r=%0d c=%0d got %h exp %h", f, r, c, col_out, exp_col(r, c));
            end
          end
        end
      end
    end
    tests_run++;
    if (sof_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_sof_err got %b exp 0", sof_err);
    end
  endtask

  task automatic test_sof_err();
    do_reset();
    for (int i = 0; i < 2 * W + 5; i++) begin
      drive(1'b1, 1'b0, pv(0, i / W, i % W));
    end
    img[0][0] = 8'hA5;
    drive(1'b1, 1'b1, 8'hA5);
    tests_run++;
    if (sof_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL sof_err_set got %b exp 1", sof_err);
    end
    tests_run++;
    if (out_valid !== 1'b0 || pixel4 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL sof_err_pixel got valid=%b p4=%h exp valid=0 p4=a5", out_valid, pixel4);
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = (r == 0) ? 1 : 0; c < W; c++) begin
        img[r][c] = pv(2, r, c);
        drive(1'b1, 1'b0, img[r][c]);
        tests_run++;
        if (out_valid !== (r == 4)) begin
          tests_failed++;
          $display("FAIL sof_err_valid r=%0d c=%0d got %b exp %b", r, c, out_valid, (r == 4));
        end
        if (r == 4) begin
          tests_run++;
          if (col_out !== exp_col(r, c)) begin
            tests_failed++;
            $display("FAIL sof_err_data r=%0d c=%0d got %h exp %h", r, c, col_out, exp_col(r, c));
          end
        end
        if (r == 4 && c == 0) begin
          tests_run++;
          if (pixel0 !== 8'hA5) begin
            tests_failed++;
            $display("FAIL sof_err_col0 got %h exp a5", pixel0);
          end
        end
      end
    end
    tests_run++;
    if (sof_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL sof_err_sticky got %b exp 1", sof_err);
    end
  endtask

  task automatic test_rst_mid();
    // Runs straight after test_sof_err, so sof_err is still set here.
    for (int i = 0; i < 4 * W + 3; i++) begin
      img[i / W][i % W] = pv(0, i / W, i % W);
      drive(1'b1, (i == 0), img[i / W][i % W]);
    end
    tests_run++;
    if (out_valid !== 1'b1 || col_out !== 40'h0212223242 || sof_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_pre got valid=%b data=%h err=%b exp 1 0212223242 1", out_valid, col_out, sof_err);
    end
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h77);
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || col_out !== 40'h0 || sof_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_clear got valid=%b data=%h err=%b exp 0 0 0", out_valid, col_out, sof_err);
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = pv(3, r, c);
        drive(1'b1, 1'b0, img[r][c]);
        tests_run++;
        if (out_valid !== (r == 4)) begin
          tests_failed++;
          $display("FAIL rst_mid_valid r=%0d c=%0d got %b exp %b", r, c, out_valid, (r == 4));
        end
        if (r == 4) begin
          tests_run++;
          if (col_out !== exp_col(r, c)) begin
            tests_failed++;
            $display("FAIL rst_mid_data r=%0d c=%0d got %h exp %h", r, c, col_out, exp_col(r, c));
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      for (int r = 0; r < 6; r++) begin
        for (int c = 0; c < W; c++) begin
          img[r][c] = pv(f, r, c);
          drive(1'b1, (r == 0 && c == 0), img[r][c]);
          tests_run++;
          if (out_valid !== (r >= 4)) begin
            tests_failed++;
            $display("FAIL b2b_valid f=%0d r=%0d c=%0d got %b exp %b", f, r, c, out_valid, (r >= 4));
          end
          if (r >= 4) begin
            tests_run++;
            if (col_out !== exp_col(r, c)) begin
              tests_failed++;
              $display("FAIL b2b_data f=%0d r=%0d c=%0d got %h exp %h", f, r, c, col_out, exp_col(r, c));
            end
          end
        end
      end
    end
    tests_run++;
    if (sof_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_sof_err got %b exp 0", sof_err);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_new_frame();
    test_sof_err();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_line_buffer.md
FIR_LINE_BUFFER -- requirements
Module: fir_line_buffer

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per image line; legal range 2..2048.
REQ-002 Parameter COL_BITS, default 11, column counter width; SHALL satisfy 2^COL_BITS >= IMG_WIDTH.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  qualifies in_pixel and in_sof.
REQ-006 in_sof  in  1  start of frame; marks the in_pixel at row 0, column 0.
REQ-007 in_pixel  in  8  unsigned raster pixel, left-to-right, top-to-bottom.
REQ-008 pixel0..pixel4  out  8 each  vertically aligned column; pixel0 = 4 lines above current row, pixel4 = current row.
REQ-009 out_valid  out  1  qualifies pixel0..pixel4 for one cycle; feeds the 5x5 FIR in_valid.
REQ-010 sof_err  out  1  sticky flag: in_sof received mid-line.

Function
REQ-011 Four line memories of IMG_WIDTH x 8 bits SHALL be organised as a circular set; the line being written rotates by one at every line wrap.
REQ-012 Column counter col SHALL increment on each accepted pixel (in_valid=1) and wrap from IMG_WIDTH-1 to 0.
REQ-013 On a col wrap, row counter SHALL increment, saturating at 4.
REQ-014 Each accepted pixel SHALL read the four stored pixels at address col and write in_pixel into the oldest line at address col in the same cycle, read-before-write.
REQ-015 Registered outputs: one cycle after an accepted pixel, pixel4 = that pixel and pixel3..pixel0 = same column from 1..4 lines earlier.
REQ-016 out_valid SHALL be 1 exactly one cycle after an accepted pixel whose row counter value is 4 (i.e. at least four full lines stored); otherwise 0.
REQ-017 in_valid=0: no counter, memory or output-data change; out_valid=0 on the next cycle; pixel0..4 hold their values.
REQ-018 Gaps in in_valid of any length, including mid-line, SHALL NOT corrupt column alignment.
REQ-019 in_sof with in_valid=1: col and row SHALL be treated as 0 for that pixel (pixel written at column 0; out_valid=0 for it), then col=1, row=0.
REQ-020 in_sof with in_valid=1 while col != 0 SHALL set sof_err=1; sof_err clears only on rst.
REQ-021 in_sof with in_valid=0 SHALL be ignored.
REQ-022 No vertical or horizontal border padding; rows 0..3 of each frame produce no out_valid; horizontal borders are passed through and handled downstream.
REQ-023 Line memory contents are not initialised; stale data SHALL never be presented with out_valid=1.

Reset
REQ-024 rst=1 SHALL clear col, row, line-rotation pointer, out_valid, sof_err and pixel0..pixel4 to 0 on the next clock edge.
REQ-025 rst SHALL take priority over in_valid and in_sof in the same cycle; memory contents are don't-care after reset.
REQ-026 rst asserted mid-frame SHALL abort the frame; the next accepted pixel is row 0, column 0 regardless of in_sof.

Verification (IMG_WIDTH=8, in_pixel = row*16 + col)
REQ-027 Reset then stream 5 lines continuously -> out_valid=0 for the first 32 pixels, then 1 for 8 consecutive cycles; at row 4 col 2 (0x42) next cycle pixel0..4 = 0x02,0x12,0x22,0x32,0x42.
REQ-028 Same stream with in_valid toggling 1/0 every cycle -> identical output sequence on out_valid cycles, out_valid=0 between them.
REQ-029 Stream 6 lines, then in_sof at new frame start -> out_valid=0 for the next 32 accepted pixels, sof_err stays 0.
REQ-030 in_sof with in_valid=1 at row 2 col 5 -> sof_err=1 persists; that pixel is stored at column 0, row 0.
REQ-031 rst pulse at row 4 col 3 -> next cycle out_valid=0, pixel0..4=0, sof_err=0; out_valid stays 0 until 32 more pixels accepted.
REQ-032 Stream 3 frames of 6 lines back-to-back -> every out_valid column matches the reference model with no stale data from the previous frame.
